// File: rtl/viterbi_pkg.sv
// Shared widths, constants, state encoding and helpers for the 4-state
// add-compare-select path-metric datapath.
package viterbi_pkg;

  localparam int METRIC_W = 5;
  localparam int BRANCH_W = 3;
  localparam int NUM_ST   = 4;

  typedef logic [METRIC_W-1:0] metric_t;
  typedef logic [BRANCH_W-1:0] branch_t;

  typedef metric_t [NUM_ST-1:0]   metric_vec_t;
  typedef branch_t [NUM_ST-1:0]   branch_vec_t;
  typedef metric_t [2*NUM_ST-1:0] sum_vec_t;

  localparam metric_t INIT_METRIC = 5'd8;
  localparam metric_t MAX_METRIC  = 5'd15;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RUN   = 3'd1,
    ST_NORM  = 3'd2,
    ST_RETRY = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  function automatic metric_t widen(input branch_t b);
    return {{(METRIC_W-BRANCH_W){1'b0}}, b};
  endfunction

  // Lowest index wins on ties.
  function automatic logic [1:0] argmin4(input metric_vec_t m);
    logic [1:0] idx;
    idx = 2'd0;
    for (int k = 1; k < NUM_ST; k++) begin
      if (m[k] < m[idx]) idx = 2'(k);
    end
    return idx;
  endfunction

endpackage

// File: rtl/compute_metric.sv
// Purely combinational: forms the eight candidate path sums of one trellis step
// and flags when any of them needs the top metric bit (overflow of the 4-bit range).
module compute_metric
  import viterbi_pkg::*;
(
  input  metric_vec_t i_m,
  input  branch_vec_t i_s,
  output sum_vec_t    o_sum,
  output logic        o_err
);

  // Even index = first candidate of pair k, odd index = second candidate.
  assign o_sum[0] = i_m[0] + widen(i_s[0]);
  assign o_sum[1] = i_m[2] + widen(i_s[2]);
  assign o_sum[2] = i_m[0] + widen(i_s[2]);
  assign o_sum[3] = i_m[2] + widen(i_s[0]);
  assign o_sum[4] = i_m[1] + widen(i_s[1]);
  assign o_sum[5] = i_m[3] + widen(i_s[3]);
  assign o_sum[6] = i_m[1] + widen(i_s[3]);
  assign o_sum[7] = i_m[3] + widen(i_s[1]);

  always_comb begin
    o_err = 1'b0;
    for (int i = 0; i < 2*NUM_ST; i++) begin
      o_err = o_err | o_sum[i][METRIC_W-1];
    end
  end

endmodule

// File: rtl/metric_ctrl.sv
// Path-metric controller: per accepted symbol, decisions appear 1 cycle later, or 3 cycles
// later when the step overflows and metrics are renormalised; sym_ready is low outside RUN.
module metric_ctrl
  import viterbi_pkg::*;
(
  input  logic                clk,
  input  logic                reset_n,
  input  logic                start,
  input  logic [7:0]          frame_len,
  input  logic                sym_valid,
  output logic                sym_ready,
  input  logic [BRANCH_W-1:0] s0,
  input  logic [BRANCH_W-1:0] s1,
  input  logic [BRANCH_W-1:0] s2,
  input  logic [BRANCH_W-1:0] s3,
  output logic                dec_valid,
  output logic [3:0]          dec,
  output logic                busy,
  output logic                done,
  output logic [1:0]          best_state,
  output logic                sat
);

  state_t      r_state;
  metric_vec_t r_m;
  branch_vec_t r_s;
  logic [7:0]  r_cnt;
  logic [7:0]  r_len;
  logic        r_dec_valid;
  logic [3:0]  r_dec;
  logic        r_done;
  logic [1:0]  r_best;
  logic        r_sat;

  branch_vec_t w_s_in;
  branch_vec_t w_s_acs;
  sum_vec_t    w_sum;
  logic        w_err;
  logic [3:0]  w_sel;
  logic [3:0]  w_clamp;
  metric_vec_t w_pick;
  metric_vec_t w_acs;
  metric_vec_t w_norm;
  metric_t     w_min;
  logic        w_accept;
  logic        w_last;

  assign w_s_in  = {s3, s2, s1, s0};
  // The retry step replays the branch metrics captured when the overflow was seen.
  assign w_s_acs = (r_state == ST_RETRY) ? r_s : w_s_in;

  compute_metric u_compute (
    .i_m   (r_m),
    .i_s   (w_s_acs),
    .o_sum (w_sum),
    .o_err (w_err)
  );

  // Ties keep the first candidate; a selected value beyond range pins to the maximum.
  always_comb begin
    w_sel   = '0;
    w_clamp = '0;
    w_pick  = '0;
    w_acs   = '0;
    w_norm  = '0;
    w_min   = r_m[argmin4(r_m)];
    for (int k = 0; k < NUM_ST; k++) begin
      w_sel[k]   = w_sum[2*k+1] < w_sum[2*k];
      w_pick[k]  = w_sel[k] ? w_sum[2*k+1] : w_sum[2*k];
      w_clamp[k] = w_pick[k] > MAX_METRIC;
      w_acs[k]   = w_clamp[k] ? MAX_METRIC : w_pick[k];
      w_norm[k]  = r_m[k] - w_min;
    end
  end

  assign w_accept = sym_valid && (r_state == ST_RUN);
  assign w_last   = (r_cnt == (r_len - 8'd1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= ST_IDLE;
      r_m         <= '0;
      r_s         <= '0;
      r_cnt       <= '0;
      r_len       <= '0;
      r_dec_valid <= 1'b0;
      r_dec       <= '0;
      r_done      <= 1'b0;
      r_best      <= '0;
      r_sat       <= 1'b0;
    end else begin
      r_dec_valid <= 1'b0;
      r_done      <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_m     <= {INIT_METRIC, INIT_METRIC, INIT_METRIC, metric_t'(0)};
            r_cnt   <= '0;
            r_len   <= frame_len;
            r_sat   <= 1'b0;
            r_state <= (frame_len == 8'd0) ? ST_DONE : ST_RUN;
          end
        end
        ST_RUN: begin
          if (w_accept) begin
            if (w_err) begin
              r_s     <= w_s_in;
              r_state <= ST_NORM;
            end else begin
              r_m         <= w_acs;
              r_dec       <= w_sel;
              r_dec_valid <= 1'b1;
              r_cnt       <= r_cnt + 8'd1;
              if (w_last) r_state <= ST_DONE;
            end
          end
        end
        ST_NORM: begin
          r_m     <= w_norm;
          r_state <= ST_RETRY;
        end
        ST_RETRY: begin
          r_m         <= w_acs;
          r_dec       <= w_sel;
          r_dec_valid <= 1'b1;
          r_cnt       <= r_cnt + 8'd1;
          if (|w_clamp) r_sat <= 1'b1;
          r_state     <= w_last ? ST_DONE : ST_RUN;
        end
        ST_DONE: begin
          r_done  <= 1'b1;
          r_best  <= argmin4(r_m);
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign sym_ready  = (r_state == ST_RUN);
  assign busy       = (r_state != ST_IDLE);
  assign dec_valid  = r_dec_valid;
  assign dec        = r_dec;
  assign done       = r_done;
  assign best_state = r_best;
  assign sat        = r_sat;

endmodule

// File: tb/tb_metric_ctrl.sv
// Randomised scoreboard bench for metric_ctrl with a table-driven trellis model.
module tb_metric_ctrl;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       start = 1'b0;
  logic [7:0] frame_len = 8'd0;
  logic       sym_valid = 1'b0;
  logic       sym_ready;
  logic [2:0] s0 = 3'd0, s1 = 3'd0, s2 = 3'd0, s3 = 3'd0;
  logic       dec_valid;
  logic [3:0] dec;
  logic       busy;
  logic       done;
  logic [1:0] best_state;
  logic       sat;

  metric_ctrl dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .start      (start),
    .frame_len  (frame_len),
    .sym_valid  (sym_valid),
    .sym_ready  (sym_ready),
    .s0         (s0),
    .s1         (s1),
    .s2         (s2),
    .s3         (s3),
    .dec_valid  (dec_valid),
    .dec        (dec),
    .busy       (busy),
    .done       (done),
    .best_state (best_state),
    .sat        (sat)
  );

  initial forever #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: trellis connectivity as tables; pair k = entries 2k, 2k+1.
  int PA[8] = '{0, 2, 0, 2, 1, 3, 1, 3};
  int SA[8] = '{0, 2, 2, 0, 1, 3, 3, 1};
  int mm[4];
  bit msat;

  typedef struct { int dbits; int cyc; } dexp_t;
  typedef struct { int best; int sat; int cyc; } doexp_t;
  dexp_t  dq[$];
  doexp_t doq[$];
  int     pend[$];

  function automatic int pk(input int a, input int b, input int c, input int d);
    return a | (b << 3) | (c << 6) | (d << 9);
  endfunction

  function automatic int model_best();
    int bi;
    bi = 0;
    for (int k = 1; k < 4; k++) if (mm[k] < mm[bi]) bi = k;
    return bi;
  endfunction

  task automatic model_step(input int sv[4], output int dbits, output int lat);
    int c[8];
    bit over;
    int lo, a, b;
    over = 0; lat = 1; dbits = 0;
    for (int i = 0; i < 8; i++) begin
      c[i] = mm[PA[i]] + sv[SA[i]];
      if (c[i] >= 16) over = 1;
    end
    if (over) begin
      lo = mm[0];
      for (int k = 1; k < 4; k++) if (mm[k] < lo) lo = mm[k];
      for (int k = 0; k < 4; k++) mm[k] = mm[k] - lo;
      for (int i = 0; i < 8; i++) c[i] = mm[PA[i]] + sv[SA[i]];
      lat = 3;
    end
    for (int k = 0; k < 4; k++) begin
      a = c[2*k];
      b = c[2*k+1];
      if (b < a) begin
        dbits = dbits | (1 << k);
        a = b;
      end
      if (a > 15) begin
        a = 15;
        msat = 1;
      end
      mm[k] = a;
    end
  endtask

  // Monitor: samples just after the falling edge, once the driver has pushed.
  initial begin
    dexp_t  d;
    doexp_t o;
    forever begin
      @(negedge clk);
      #1;
      if (reset_n) begin
        if (dec_valid) begin
          if (dq.size() == 0) begin
            checks++; errors++;
            $display("FAIL dec_unexpected: dec_valid=1 dec=%0d, expected no pulse", dec);
          end else begin
            d = dq.pop_front();
            check("dec", int'(dec), d.dbits);
            check("dec_cycle", cyc, d.cyc);
          end
        end
        if (done) begin
          if (doq.size() == 0) begin
            checks++; errors++;
            $display("FAIL done_unexpected: done=1, expected no pulse");
          end else begin
            o = doq.pop_front();
            check("best_state", int'(best_state), o.best);
            check("sat", int'(sat), o.sat);
            check("done_cycle", cyc, o.cyc);
            check("busy_at_done", int'(busy), 0);
          end
        end
      end
    end
  end

  task automatic push_done(input int at);
    doexp_t o;
    o.best = model_best();
    o.sat  = int'(msat);
    o.cyc  = at;
    doq.push_back(o);
  endtask

  task automatic start_frame(input int len, output int t);
    start = 1'b1;
    frame_len = 8'(len);
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    frame_len = 8'($urandom_range(0, 255));
    t = cyc;
    mm = '{0, 8, 8, 8};
    msat = 0;
    check("busy_after_start", int'(busy), 1);
  endtask

  task automatic send_sym(input int p, input bit inj, output int t, output int lat);
    int sv[4];
    int dbits, to;
    dexp_t d;
    for (int k = 0; k < 4; k++) sv[k] = (p >> (3*k)) & 7;
    s0 = 3'(sv[0]); s1 = 3'(sv[1]); s2 = 3'(sv[2]); s3 = 3'(sv[3]);
    sym_valid = 1'b1;
    if (inj) begin
      start = 1'b1;
      frame_len = 8'($urandom_range(0, 255));
    end
    to = 0;
    while (!sym_ready && to < 50) begin
      @(negedge clk);
      to++;
    end
    t = cyc;
    lat = 1;
    if (!sym_ready) begin
      checks++; errors++;
      $display("FAIL ready_timeout: sym_ready=0 after %0d cycles, expected 1", to);
      sym_valid = 1'b0;
      start = 1'b0;
      return;
    end
    @(posedge clk);
    @(negedge clk);
    sym_valid = 1'b0;
    start = 1'b0;
    t = cyc;
    model_step(sv, dbits, lat);
    d.dbits = dbits;
    d.cyc   = t + lat - 1;
    dq.push_back(d);
  endtask

  task automatic wait_drain();
    int to;
    to = 0;
    while ((dq.size() != 0 || doq.size() != 0) && to < 40) begin
      @(negedge clk);
      to++;
    end
    if (dq.size() != 0 || doq.size() != 0) begin
      checks++; errors++;
      $display("FAIL drain_timeout: %0d dec and %0d done still pending, expected 0", dq.size(), doq.size());
      dq.delete();
      doq.delete();
    end
    @(negedge clk);
  endtask

  task automatic run_frame(input int len, input int inj);
    int t, lat, p;
    start_frame(len, t);
    if (len == 0) begin
      push_done(t + 1);
    end else begin
      for (int i = 0; i < len; i++) begin
        if (i > 0 && $urandom_range(0, 3) == 0) repeat ($urandom_range(1, 2)) @(negedge clk);
        p = (pend.size() != 0) ? pend.pop_front() : int'($urandom_range(0, 4095));
        send_sym(p, (i == inj), t, lat);
      end
      push_done(t + lat);
    end
    wait_drain();
  endtask

  initial begin
    int t, lat, len;
    #100_000_000;
    $display("FAIL watchdog: simulation still running, expected completion");
    $fatal(1);
  end

  initial begin
    int t, lat, len;
    repeat (3) @(negedge clk);
    check("rst_sym_ready", int'(sym_ready), 0);
    check("rst_dec_valid", int'(dec_valid), 0);
    check("rst_dec", int'(dec), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_best_state", int'(best_state), 0);
    check("rst_sat", int'(sat), 0);
    reset_n = 1'b1;
    @(negedge clk);

    pend.push_back(pk(0, 2, 2, 0));
    pend.push_back(pk(1, 1, 1, 1));
    run_frame(2, -1);

    pend.push_back(pk(3, 3, 3, 3));
    run_frame(1, -1);

    run_frame(0, -1);

    // Build metrics {12,9,14,13}, then force an overflowing step.
    start_frame(4, t);
    send_sym(pk(5, 0, 7, 0), 1'b0, t, lat);
    send_sym(pk(7, 7, 4, 6), 1'b0, t, lat);
    send_sym(pk(7, 7, 7, 7), 1'b0, t, lat);
    check("ready_drop_1", int'(sym_ready), 0);
    @(negedge clk);
    check("ready_drop_2", int'(sym_ready), 0);
    @(negedge clk);
    check("ready_back", int'(sym_ready), 1);
    send_sym(int'($urandom_range(0, 4095)), 1'b0, t, lat);
    push_done(t + lat);
    wait_drain();

    // Same overflow again, but reset lands while the metrics are normalising.
    start_frame(3, t);
    send_sym(pk(5, 0, 7, 0), 1'b0, t, lat);
    send_sym(pk(7, 7, 4, 6), 1'b0, t, lat);
    send_sym(pk(7, 7, 7, 7), 1'b0, t, lat);
    check("busy_in_norm", int'(busy), 1);
    #2;
    reset_n = 1'b0;
    #1;
    check("arst_sym_ready", int'(sym_ready), 0);
    check("arst_dec_valid", int'(dec_valid), 0);
    check("arst_dec", int'(dec), 0);
    check("arst_busy", int'(busy), 0);
    check("arst_done", int'(done), 0);
    check("arst_best_state", int'(best_state), 0);
    check("arst_sat", int'(sat), 0);
    dq.delete();
    doq.delete();
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (6) @(negedge clk);
    pend.push_back(pk(0, 2, 2, 0));
    pend.push_back(pk(1, 1, 1, 1));
    run_frame(2, -1);

    run_frame(8, 3);

    for (int f = 0; f < 30; f++) begin
      len = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 12));
      run_frame(len, int'($urandom_range(0, 12)));
      if ($urandom_range(0, 1) == 1) begin
        sym_valid = 1'b1;
        s0 = 3'($urandom_range(0, 7)); s1 = 3'($urandom_range(0, 7));
        s2 = 3'($urandom_range(0, 7)); s3 = 3'($urandom_range(0, 7));
        repeat (2) @(negedge clk);
        sym_valid = 1'b0;
        repeat (2) @(negedge clk);
      end
    end

    wait_drain();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
